// File: rtl/sdram_arbiter_if.sv
// Bus bundle for sdram_arbiter: read channels, ioctl download stream and the SDRAM controller port.
// The arbiter connects through the slave modport; the requesting side uses master.
interface sdram_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 23
);
   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH-1:0]        ch_ack;
   logic [NUM_CH-1:0]        ch_valid;
   logic [31:0]              ch_data;

   logic [24:0]              ioctl_addr;
   logic [7:0]               ioctl_data;
   logic [15:0]              ioctl_index;
   logic                     ioctl_wr;
   logic                     ioctl_download;

   logic [ADDR_W-1:0]        sdram_addr;
   logic [31:0]              sdram_data;
   logic                     sdram_we;
   logic                     sdram_req;
   logic                     sdram_ack;
   logic                     sdram_valid;
   logic [31:0]              sdram_q;

   logic                     stray_valid;
   logic                     dl_overrun;

   modport slave (
      input  ch_req, ch_addr, ioctl_addr, ioctl_data, ioctl_index, ioctl_wr, ioctl_download,
             sdram_ack, sdram_valid, sdram_q,
      output ch_ack, ch_valid, ch_data, sdram_addr, sdram_data, sdram_we, sdram_req,
             stray_valid, dl_overrun
   );

   modport master (
      output ch_req, ch_addr, ioctl_addr, ioctl_data, ioctl_index, ioctl_wr, ioctl_download,
             sdram_ack, sdram_valid, sdram_q,
      input  ch_ack, ch_valid, ch_data, sdram_addr, sdram_data, sdram_we, sdram_req,
             stray_valid, dl_overrun
   );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM request arbiter: N read channels (fixed or round-robin) plus the packed ioctl write path.
// Read data is steered back to its channel through an in-order tag FIFO.
module sdram_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 23,
   parameter int RR_MODE   = 0,
   parameter int TAG_DEPTH = 4,
   parameter int DL_INDEX  = 0
) (
   input logic            clk,
   input logic            reset,
   sdram_arbiter_if.slave bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, CH_REQ, DL_REQ} state_t;

   state_t            state, state_next;
   logic [CH_W-1:0]   grant_q, grant_next, rr_ptr, rr_idx;
   logic              grant_found;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;

   logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              fifo_full, fifo_empty, push, pop;

   logic [23:0]       pack_buf;
   logic [31:0]       dl_data;
   logic [ADDR_W-1:0] dl_addr;
   logic              dl_pending, dl_byte, dl_word, dl_done;
   logic              stray_q, overrun_q;

   assign fifo_full  = (count == (PTR_W+1)'(TAG_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = (state == CH_REQ) && bus.sdram_ack;
   assign pop        = bus.sdram_valid && !fifo_empty;
   assign dl_done    = (state == DL_REQ) && bus.sdram_ack;
   assign dl_byte    = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == 16'(DL_INDEX));
   assign dl_word    = dl_byte && (bus.ioctl_addr[1:0] == 2'd3);

   // NOTE: every variable written in always_comb gets a default first; a path that skips
   // an assignment would otherwise infer a latch.
   always_comb begin
      grant_found = 1'b0;
      grant_next  = '0;
      rr_idx      = '0;
      // Walk from the far end toward the preferred channel so the preferred one wins.
      if (RR_MODE != 0) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            rr_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (bus.ch_req[rr_idx]) begin
               grant_found = 1'b1;
               grant_next  = rr_idx;
            end
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_req[i]) begin
               grant_found = 1'b1;
               grant_next  = CH_W'(i);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (bus.ioctl_download) begin
               if (dl_pending) state_next = DL_REQ;
            end else if (grant_found && !fifo_full) begin
               state_next = CH_REQ;
            end
         end
         CH_REQ, DL_REQ: if (bus.sdram_ack) state_next = IDLE;
         default:        state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.sdram_req  = 1'b0;
      bus.sdram_we   = 1'b0;
      bus.sdram_addr = '0;
      bus.sdram_data = '0;
      bus.ch_ack     = '0;
      bus.ch_valid   = '0;
      unique case (state)
         CH_REQ: begin
            bus.sdram_req  = 1'b1;
            bus.sdram_addr = addr_q;
            if (bus.sdram_ack) bus.ch_ack[grant_q] = 1'b1;
         end
         DL_REQ: begin
            bus.sdram_req  = 1'b1;
            bus.sdram_we   = 1'b1;
            bus.sdram_addr = addr_q;
            bus.sdram_data = data_q;
         end
         default: ;
      endcase
      if (pop) bus.ch_valid[tag_mem[rd_ptr]] = 1'b1;
   end

   assign bus.ch_data     = bus.sdram_q;
   assign bus.stray_valid = stray_q;
   assign bus.dl_overrun  = overrun_q;

   // NOTE: tag storage has no reset; only the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= grant_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= CH_W'(NUM_CH - 1);
         grant_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pack_buf   <= '0;
         dl_data    <= '0;
         dl_addr    <= '0;
         dl_pending <= 1'b0;
         stray_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (state == IDLE && state_next == CH_REQ) begin
            grant_q <= grant_next;
            addr_q  <= bus.ch_addr[int'(grant_next)*ADDR_W +: ADDR_W];
         end
         if (state == IDLE && state_next == DL_REQ) begin
            addr_q <= dl_addr;
            data_q <= dl_data;
         end

         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            rr_ptr <= grant_q;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);
         if (bus.sdram_valid && fifo_empty) stray_q <= 1'b1;

         if (dl_byte) begin
            unique case (bus.ioctl_addr[1:0])
               2'd0: pack_buf[7:0]   <= bus.ioctl_data;
               2'd1: pack_buf[15:8]  <= bus.ioctl_data;
               2'd2: pack_buf[23:16] <= bus.ioctl_data;
               default: begin
                  dl_data <= {bus.ioctl_data, pack_buf};
                  dl_addr <= ADDR_W'(bus.ioctl_addr[24:2]);
               end
            endcase
         end
         // A word finishing in the same cycle the previous write is acked is not an overrun.
         if (dl_word) begin
            dl_pending <= 1'b1;
            if (dl_pending && !dl_done) overrun_q <= 1'b1;
         end else if (dl_done) begin
            dl_pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one fixed-priority and one round-robin instance.
module tb_sdram_arbiter;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sdram_arbiter_if #(.NUM_CH(4), .ADDR_W(23)) fb ();
   sdram_arbiter_if #(.NUM_CH(4), .ADDR_W(23)) rb ();

   sdram_arbiter #(.NUM_CH(4), .ADDR_W(23), .RR_MODE(0), .TAG_DEPTH(4), .DL_INDEX(0)) dut_fp (
      .clk(clk), .reset(reset), .bus(fb.slave));
   sdram_arbiter #(.NUM_CH(4), .ADDR_W(23), .RR_MODE(1), .TAG_DEPTH(4), .DL_INDEX(0)) dut_rr (
      .clk(clk), .reset(reset), .bus(rb.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
      fb.ioctl_addr = a;
      fb.ioctl_data = d;
      fb.ioctl_wr   = 1'b1;
      step();
      fb.ioctl_wr   = 1'b0;
   endtask

   initial begin
      int exp_ch;
      fb.ch_req = '0; fb.ch_addr = {23'h1003, 23'h1002, 23'h1001, 23'h1000};
      rb.ch_req = '0; rb.ch_addr = {23'h2003, 23'h2002, 23'h2001, 23'h2000};
      fb.ioctl_addr = '0; fb.ioctl_data = '0; fb.ioctl_index = '0; fb.ioctl_wr = 0; fb.ioctl_download = 0;
      rb.ioctl_addr = '0; rb.ioctl_data = '0; rb.ioctl_index = '0; rb.ioctl_wr = 0; rb.ioctl_download = 0;
      fb.sdram_ack = 0; fb.sdram_valid = 0; fb.sdram_q = 32'hDEADBEEF;
      rb.sdram_ack = 0; rb.sdram_valid = 0; rb.sdram_q = '0;

      // Reset state
      step(); step();
      check("rst_req", fb.sdram_req, 0);
      check("rst_we", fb.sdram_we, 0);
      check("rst_addr", fb.sdram_addr, 0);
      check("rst_data", fb.sdram_data, 0);
      check("rst_ack", fb.ch_ack, 0);
      check("rst_valid", fb.ch_valid, 0);
      check("rst_stray", fb.stray_valid, 0);
      check("rst_ovr", fb.dl_overrun, 0);
      check("rst_chdata", fb.ch_data, 32'hDEADBEEF);
      check("rst_rr_req", rb.sdram_req, 0);
      reset = 1'b0;
      step();

      // Fixed priority: channel 1 wins over 3 while it keeps requesting
      fb.ch_req = 4'b1010;
      settle();
      check("fp_latency", fb.sdram_req, 0);
      for (int n = 0; n < 2; n++) begin
         step();
         check("fp_req", fb.sdram_req, 1);
         check("fp_addr", fb.sdram_addr, 23'h1001);
         check("fp_we", fb.sdram_we, 0);
         fb.sdram_ack = 1;
         settle();
         check("fp_ack", fb.ch_ack, 4'b0010);
         check("fp_req_in_ack", fb.sdram_req, 1);
         step();
         fb.sdram_ack = 0;
         if (n == 1) fb.ch_req = 4'b1000;
         settle();
         check("fp_drop", fb.sdram_req, 0);
         check("fp_ack_gone", fb.ch_ack, 0);
      end
      step();
      check("fp_ch3_addr", fb.sdram_addr, 23'h1003);
      fb.sdram_ack = 1;
      settle();
      check("fp_ch3_ack", fb.ch_ack, 4'b1000);
      step();
      fb.sdram_ack = 0;
      fb.ch_req = 4'b0001;
      step();
      check("fp_ch0_addr", fb.sdram_addr, 23'h1000);
      fb.sdram_ack = 1;
      settle();
      check("fp_ch0_ack", fb.ch_ack, 4'b0001);

      // FIFO full (tags 1,1,3,0): no further grant until a pop
      step();
      fb.sdram_ack = 0;
      fb.ch_req = 4'b0100;
      settle();
      check("full_hold0", fb.sdram_req, 0);
      step();
      check("full_hold1", fb.sdram_req, 0);
      fb.sdram_valid = 1;
      fb.sdram_q = 32'h0000_00A0;
      settle();
      check("pop0", fb.ch_valid, 4'b0010);
      check("pop0_data", fb.ch_data, 32'h0000_00A0);
      step();
      check("pop1", fb.ch_valid, 4'b0010);
      check("pop1_req", fb.sdram_req, 0);
      step();
      check("fifth_req", fb.sdram_req, 1);
      check("fifth_addr", fb.sdram_addr, 23'h1002);
      check("pop2", fb.ch_valid, 4'b1000);
      fb.sdram_ack = 1;
      settle();
      check("fifth_ack", fb.ch_ack, 4'b0100);
      step();
      fb.sdram_ack = 0;
      fb.ch_req = 4'b0000;
      settle();
      check("pop3", fb.ch_valid, 4'b0001);
      step();
      check("pop4", fb.ch_valid, 4'b0100);
      check("no_stray_yet", fb.stray_valid, 0);
      step();
      check("empty_valid", fb.ch_valid, 0);
      step();
      fb.sdram_valid = 0;
      check("stray", fb.stray_valid, 1);

      // Round-robin: all four requesting, grant order 0,1,2,3,0
      rb.ch_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_ch = n % 4;
         step();
         rb.sdram_valid = 0;
         check("rr_req", rb.sdram_req, 1);
         check("rr_addr", rb.sdram_addr, 23'h2000 + exp_ch);
         rb.sdram_ack = 1;
         settle();
         check("rr_ack", rb.ch_ack, 4'b0001 << exp_ch);
         step();
         rb.sdram_ack = 0;
         rb.sdram_valid = 1;
         settle();
         check("rr_valid", rb.ch_valid, 4'b0001 << exp_ch);
      end
      rb.ch_req = '0;
      step();
      rb.sdram_valid = 0;
      check("rr_idle", rb.sdram_req, 0);
      check("rr_no_stray", rb.stray_valid, 0);

      // Download packing
      fb.ioctl_download = 1;
      fb.ioctl_index = 16'd0;
      dl_write(25'h100, 8'h11);
      dl_write(25'h101, 8'h22);
      dl_write(25'h102, 8'h33);
      dl_write(25'h103, 8'h44);
      settle();
      check("dl_wait", fb.sdram_req, 0);
      step();
      check("dl_req", fb.sdram_req, 1);
      check("dl_we", fb.sdram_we, 1);
      check("dl_addr", fb.sdram_addr, 23'h40);
      check("dl_data", fb.sdram_data, 32'h44332211);
      step();
      check("dl_hold_req", fb.sdram_req, 1);
      check("dl_hold_data", fb.sdram_data, 32'h44332211);
      fb.sdram_ack = 1;
      step();
      fb.sdram_ack = 0;
      settle();
      check("dl_done_req", fb.sdram_req, 0);
      check("dl_done_we", fb.sdram_we, 0);
      check("dl_no_ovr", fb.dl_overrun, 0);

      fb.ioctl_index = 16'd1;
      dl_write(25'h104, 8'h55);
      dl_write(25'h105, 8'h66);
      dl_write(25'h106, 8'h77);
      dl_write(25'h107, 8'h88);
      step();
      step();
      check("idx_ignored", fb.sdram_req, 0);
      fb.ioctl_index = 16'd0;

      // Two words complete while a read is in flight: overrun, second word wins
      fb.ioctl_download = 0;
      fb.ch_req = 4'b0001;
      step();
      check("ovr_rd_req", fb.sdram_req, 1);
      fb.ioctl_download = 1;
      for (int i = 0; i < 8; i++) dl_write(25'h200 + i, 8'hA0 + 8'(i));
      settle();
      check("ovr_flag", fb.dl_overrun, 1);
      check("ovr_rd_hold_we", fb.sdram_we, 0);
      check("ovr_rd_hold_addr", fb.sdram_addr, 23'h1000);
      fb.sdram_ack = 1;
      settle();
      check("ovr_rd_ack", fb.ch_ack, 4'b0001);
      step();
      fb.sdram_ack = 0;
      fb.ch_req = '0;
      settle();
      check("ovr_gap", fb.sdram_req, 0);
      step();
      check("ovr_we", fb.sdram_we, 1);
      check("ovr_addr", fb.sdram_addr, 23'h81);
      check("ovr_data", fb.sdram_data, 32'hA7A6A5A4);
      fb.sdram_ack = 1;
      step();
      fb.sdram_ack = 0;
      settle();
      check("ovr_after", fb.sdram_req, 0);
      step();
      check("ovr_single", fb.sdram_req, 0);

      // Reset with a read in flight and two tags outstanding
      fb.ioctl_download = 0;
      fb.ch_req = 4'b0010;
      step();
      fb.sdram_ack = 1;
      step();
      fb.sdram_ack = 0;
      fb.ch_req = 4'b0100;
      step();
      check("pre_rst_req", fb.sdram_req, 1);
      check("pre_rst_addr", fb.sdram_addr, 23'h1002);
      reset = 1;
      fb.ch_req = '0;
      step();
      check("mid_rst_req", fb.sdram_req, 0);
      check("mid_rst_addr", fb.sdram_addr, 0);
      check("mid_rst_ovr", fb.dl_overrun, 0);
      check("mid_rst_stray", fb.stray_valid, 0);
      reset = 0;
      fb.sdram_valid = 1;
      settle();
      check("mid_rst_fifo_empty", fb.ch_valid, 0);
      step();
      fb.sdram_valid = 0;
      check("mid_rst_stray_after", fb.stray_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Parametrised SDRAM request arbiter between N ROM-fetch channels, plus the ioctl download write path. It serves the 32-bit SDRAM controller port. Arbitration is selectable between fixed priority and round-robin. Returned data is routed back through an in-order tag FIFO, so the SDRAM may have several reads outstanding. Download bytes are packed into 32-bit writes, each held until the SDRAM acknowledges it.

## Interface
Parameters:
- NUM_CH, 4: number of read channels (1..8); channel 0 has the highest fixed priority.
- ADDR_W, 23: SDRAM word address width.
- RR_MODE, 0: 0 = fixed priority; 1 = round-robin.
- TAG_DEPTH, 4: maximum outstanding reads (power of two, ≥2).
- DL_INDEX, 0: ioctl_index value that enables SDRAM writes.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- ch_req  in  NUM_CH  level request per channel; held until that channel's ch_ack.
- ch_addr  in  NUM_CH*ADDR_W  word address per channel; channel i occupies bits [i*ADDR_W +: ADDR_W]; offset already applied.
- ch_ack  out  NUM_CH  one-cycle pulse: the channel's request was accepted by the SDRAM.
- ch_valid  out  NUM_CH  one-cycle pulse: ch_data belongs to this channel.
- ch_data  out  32  sdram_q passthrough.
- ioctl_addr  in  25, ioctl_data  in  8, ioctl_index  in  16, ioctl_wr  in  1, ioctl_download  in  1  ROM download stream (byte address).
- sdram_addr  out  ADDR_W, sdram_data  out  32, sdram_we  out  1, sdram_req  out  1  registered request to the SDRAM.
- sdram_ack  in  1, sdram_valid  in  1, sdram_q  in  32  SDRAM responses.
- stray_valid  out  1  sticky: sdram_valid arrived while the tag FIFO was empty.
- dl_overrun  out  1  sticky: a download word completed while the previous write was still unacknowledged.

## Operation
- Three states:
  - IDLE: no request in flight.
  - CH_REQ: channel read in flight.
  - DL_REQ: download write in flight.
- Reset: state IDLE, FIFO empty, rr pointer = NUM_CH-1, pack buffer = 0, sticky flags cleared. Every output is 0, except ch_data, which follows sdram_q.
- IDLE, ioctl_download=1:
  - No channel is granted.
  - When a pending download word exists, go to DL_REQ.
- IDLE, ioctl_download=0:
  - If any ch_req is set and the FIFO is not full, register the grant and go to CH_REQ.
  - Grant choice: fixed mode takes the lowest requesting index; RR mode takes the first requester after the rr pointer, with modulo-NUM_CH wrap.
- CH_REQ:
  - sdram_req=1, sdram_we=0, sdram_addr = address of the granted channel, latched at grant.
  - On sdram_ack: ch_ack[grant]=1 in that same cycle, push the grant index into the FIFO, rr pointer ← grant, return to IDLE.
- DL_REQ:
  - sdram_req=1, sdram_we=1, sdram_addr and sdram_data as latched for the pending word.
  - On sdram_ack: clear the pending flag, return to IDLE.
- Download packing:
  - Active only when ioctl_download & ioctl_wr & (ioctl_index==DL_INDEX).
  - Byte goes to lane ioctl_addr[1:0]; lane 0 = bits [7:0], little-endian.
  - Lane 3 completes the word: latch packed data, latch address ioctl_addr[24:2], set pending.
  - If pending is already set at that point, set dl_overrun; the new word replaces the old one.
  - Writes with any other ioctl_index are ignored.
- Data return:
  - On sdram_valid with the FIFO not empty, ch_valid[head]=1 in that same cycle and the head is popped.
  - On sdram_valid with the FIFO empty, nothing is pulsed and stray_valid is set.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
- ioctl_download rising while CH_REQ is in flight: the read completes normally first; download words wait in pending.
- Reset mid-operation drops the in-flight request and empties the FIFO.

## Timing
- Grant latency: ch_req seen in IDLE at cycle N gives sdram_req=1 with the channel address at cycle N+1.
- sdram_req, sdram_addr and sdram_we stay stable until and including the sdram_ack cycle; all three drop the cycle after.
- Back-to-back issue: ack at cycle M, next grant decision at M+1, next sdram_req at M+2.
- A channel must deassert ch_req by the cycle after its ch_ack; otherwise it is re-granted as a new request.
- ch_ack and ch_valid are combinational from sdram_ack and sdram_valid, gated by registered state; no added latency.
- FIFO full: IDLE does not grant, and sdram_req stays 0 until a pop frees a slot.
- Download word completed at cycle N, state IDLE: sdram_req=1, we=1 at cycle N+2.

## Test plan
- Fixed mode, ch_req=4'b1010 held, one-cycle ack each time → grants in order 1,1,…; channel 3 starves while channel 1 keeps requesting. Channel 1 drops → channel 3 is granted.
- RR_MODE=1, ch_req=4'b1111 re-asserted after each ack → grant order 0,1,2,3,0.
- TAG_DEPTH=4, four acks with no valid → fifth request withheld (sdram_req=0). Four valids → ch_valid pulses in issue order, then the fifth is issued.
- Download bytes 0x11,0x22,0x33,0x44 at ioctl_addr 0x100..0x103 → one write with addr 0x40, data 0x44332211, we=1, held until ack. ioctl_index=1 → no write.
- Two words completed without an ack in between → dl_overrun=1, only the second word is written. sdram_valid with an empty FIFO → stray_valid=1.
- Reset asserted in CH_REQ with 2 tags outstanding → next cycle sdram_req=0, FIFO empty, all outputs 0.
